// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
//
// A WIDTH-bit word is accepted on a rising edge where in_valid and in_ready
// are both high, then shifted out LSB first on sdata, one bit per cycle,
// optionally followed by one even-parity bit. A word accepted during the
// last bit of a frame starts on the next cycle, so frames run back to back
// with no gap.
//
// Parameters
//   WIDTH     : data bits per frame (2..32)
//   PARITY_EN : 1 appends an even-parity bit after the data bits
//
// Ports
//   aclk     in   clock, rising edge
//   arst     in   asynchronous active-high reset
//   in_valid in   upstream word presented
//   in_data  in   parallel word to send
//   in_ready out  word accepted this cycle if in_valid is high
//   sdata    out  serial data (registered)
//   sframe   out  high on every cycle sdata carries a frame bit (registered)
//   busy     out  high while a frame is in progress
module piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy
);

  localparam int unsigned FrameLen = WIDTH + PARITY_EN;
  localparam int unsigned CntW     = $clog2(FrameLen);

  localparam logic [CntW-1:0] LastCnt  = CntW'(FrameLen - 1);
  // Counter value of the last data bit; the parity bit follows it.
  localparam logic [CntW-1:0] DataLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;

  logic accept;
  logic last_bit;

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  // Ready in idle or on the final frame bit; forced low while reset is held.
  assign in_ready = ~arst & ((state_q == StIdle) | last_bit);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    sdata_d  = 1'b0;
    sframe_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StShift;
          cnt_d    = '0;
          // Bit 0 goes straight to the output register; the rest wait.
          shreg_d  = {1'b0, in_data[WIDTH-1:1]};
          par_d    = ^in_data;
          sdata_d  = in_data[0];
          sframe_d = 1'b1;
        end
      end

      StShift: begin
        if (last_bit) begin
          if (accept) begin
            state_d  = StShift;
            cnt_d    = '0;
            shreg_d  = {1'b0, in_data[WIDTH-1:1]};
            par_d    = ^in_data;
            sdata_d  = in_data[0];
            sframe_d = 1'b1;
          end else begin
            state_d  = StIdle;
            cnt_d    = '0;
            shreg_d  = '0;
          end
        end else begin
          cnt_d    = cnt_q + 1'b1;
          sframe_d = 1'b1;
          if ((PARITY_EN != 0) && (cnt_q == DataLast)) begin
            sdata_d = par_q;
          end else begin
            sdata_d = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
    end
  end

  assign sdata  = sdata_q;
  assign sframe = sframe_q;
  assign busy   = (state_q == StShift);

  // Structural invariants.
  cnt_in_range_a : assert property (@(posedge aclk) disable iff (arst) cnt_q <= LastCnt);
  sframe_busy_a  : assert property (@(posedge aclk) disable iff (arst) sframe_q == busy);
  idle_quiet_a   : assert property (@(posedge aclk) disable iff (arst)
                                    (state_q == StIdle) |-> (!sdata_q && cnt_q == '0));

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx. Two instances run side by side: lane 0 without
// parity, lane 1 with parity. A per-lane cycle model pushes expected serial
// bits on acceptance; a negedge monitor pops and compares them and checks
// in_ready / sframe / busy every cycle.
module tb_piso_tx;

  logic       clk;
  logic       arst;
  logic       vld [2];
  logic [7:0] dat [2];

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned F = 8 + g;

    logic rdy;
    logic sd;
    logic sf;
    logic bz;

    piso_tx #(
      .WIDTH    (8),
      .PARITY_EN(g)
    ) u_dut (
      .aclk    (clk),
      .arst    (arst),
      .in_valid(vld[g]),
      .in_data (dat[g]),
      .in_ready(rdy),
      .sdata   (sd),
      .sframe  (sf),
      .busy    (bz)
    );

    bit q[$];
    int rem;
    int acc;

    // Reference model: frame bits remaining, expected bit queue.
    initial begin
      rem = 0;
      acc = 0;
      forever begin
        @(posedge clk or posedge arst);
        if (arst) begin
          q.delete();
          rem = 0;
        end else if (vld[g] && rem <= 1) begin
          for (int i = 0; i < 8; i++) q.push_back(dat[g][i]);
          if (g == 1) q.push_back(^dat[g]);
          rem = F;
          acc++;
        end else if (rem > 0) begin
          rem--;
        end
      end
    end

    // Monitor: sample away from the active edge.
    initial begin
      bit exp_bit;
      bit exp_frame;
      forever begin
        @(negedge clk);
        exp_frame = !arst && rem > 0;
        check($sformatf("l%0d_ready", g), 32'(rdy), 32'(!arst && rem <= 1));
        check($sformatf("l%0d_sframe", g), 32'(sf), 32'(exp_frame));
        check($sformatf("l%0d_busy", g), 32'(bz), 32'(exp_frame));
        if (exp_frame) begin
          if (q.size() == 0) begin
            check($sformatf("l%0d_queue_empty", g), 32'(q.size()), 32'd1);
          end else begin
            exp_bit = q.pop_front();
            check($sformatf("l%0d_sdata", g), 32'(sd), 32'(exp_bit));
          end
        end else begin
          check($sformatf("l%0d_sdata_idle", g), 32'(sd), 32'd0);
        end
      end
    end
  end

  function automatic int get_acc(input int g);
    return (g == 0) ? g_lane[0].acc : g_lane[1].acc;
  endfunction

  // Present a word and wait (bounded) for the model to see it accepted.
  task automatic send(input int g, input logic [7:0] w, input bit drop);
    int a0;
    a0     = get_acc(g);
    vld[g] = 1'b1;
    dat[g] = w;
    for (int i = 0; i < 40 && get_acc(g) == a0; i++) begin
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 32'(get_acc(g) - a0), 32'd1);
    if (drop) begin
      vld[g] = 1'b0;
      dat[g] = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a0;
    n_cmp  = 0;
    n_err  = 0;
    arst   = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    dat[0] = 8'h00;
    dat[1] = 8'h00;

    #22;
    arst = 1'b0;
    #1;

    // Idle after reset, junk data with valid low.
    dat[0] = 8'h5A;
    idle(20);

    // Single word.
    send(0, 8'hA5, 1'b1);
    idle(12);

    // Back to back with valid held.
    send(0, 8'h01, 1'b0);
    send(0, 8'h80, 1'b1);
    idle(20);

    // Parity lane.
    send(1, 8'h07, 1'b1);
    idle(12);
    send(1, 8'h03, 1'b1);
    idle(12);
    send(1, 8'hC3, 1'b0);
    send(1, 8'h5E, 1'b1);
    idle(22);

    // Stall: one-cycle valid pulse mid-frame must not be accepted.
    send(0, 8'h3C, 1'b1);
    idle(2);
    a0     = get_acc(0);
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    idle(1);
    vld[0] = 1'b0;
    idle(15);
    check("stall_no_accept", 32'(get_acc(0)), 32'(a0));

    // Reset mid-frame, asserted between edges during the 4th bit.
    send(0, 8'hFF, 1'b1);
    idle(3);
    #1;
    arst = 1'b1;
    #1;
    check("rst_sdata", 32'(g_lane[0].sd), 32'd0);
    check("rst_sframe", 32'(g_lane[0].sf), 32'd0);
    check("rst_busy", 32'(g_lane[0].bz), 32'd0);
    check("rst_ready", 32'(g_lane[0].rdy), 32'd0);
    idle(2);
    // Word presented during reset is accepted on the first edge after release.
    vld[0] = 1'b1;
    dat[0] = 8'h0F;
    a0     = get_acc(0);
    #2;
    arst = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_accept", 32'(get_acc(0) - a0), 32'd1);
    vld[0] = 1'b0;
    idle(15);

    // Both lanes at once.
    send(0, 8'h96, 1'b1);
    send(1, 8'h69, 1'b1);
    idle(15);

    check("drain_l0", 32'(g_lane[0].q.size()), 32'd0);
    check("drain_l1", 32'(g_lane[1].q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per frame, legal range 2..32.
REQ-002 The block SHALL have parameter PARITY_EN, default 0: 1 appends one even-parity bit after the data bits.
REQ-003 The block SHALL have port aclk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is presented.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: parallel word to send.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port sdata, output, 1 bit: serial data, registered.
REQ-009 The block SHALL have port sframe, output, 1 bit: high on every cycle sdata carries a frame bit, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-011 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_data is captured into an internal shift register on that edge.
REQ-012 in_data SHALL be ignored on all edges without acceptance.
REQ-013 The state machine SHALL have two states. IDLE: moves to SHIFT on acceptance, else stays in IDLE.
REQ-014 SHIFT: after the last frame bit, moves to SHIFT on acceptance and to IDLE without acceptance.
REQ-015 The frame length SHALL be F = WIDTH + PARITY_EN cycles.
REQ-016 If acceptance occurs at edge k, then on cycles k+1 .. k+WIDTH sdata SHALL carry in_data[0] .. in_data[WIDTH-1], LSB first, with sframe=1.
REQ-017 If PARITY_EN=1, on cycle k+WIDTH+1 sdata SHALL equal the XOR of all captured bits, with sframe=1.
REQ-018 A bit counter of width clog2(F) SHALL count 0..F-1 during SHIFT and SHALL reload to 0 on acceptance; it SHALL never pass F-1.
REQ-019 in_ready SHALL be 1 in IDLE and 1 during the last frame-bit cycle of SHIFT; it SHALL be 0 in all other cycles and whenever arst=1.
REQ-020 A word accepted during the last frame bit SHALL start its frame on the next cycle, with no gap: sframe stays 1 continuously across frames.
REQ-021 With no acceptance after the last bit, sframe and busy SHALL fall to 0 on the next cycle, and sdata SHALL return to 0.
REQ-022 busy SHALL equal (state == SHIFT).
REQ-023 in_valid deasserting in a cycle where in_ready=0 SHALL have no effect; there is no requirement that in_valid be held.

Reset
REQ-024 While arst=1, the following SHALL hold immediately (asynchronous): state=IDLE, counter=0, shift register=0, sdata=0, sframe=0, busy=0, in_ready=0.
REQ-025 arst asserted mid-frame SHALL abort the frame with no further bits emitted; the partially sent word is discarded.
REQ-026 After arst deasserts, in_ready SHALL be 1 from the first cycle, and the first acceptance SHALL be possible on the first rising edge with arst=0.

Verification
REQ-027 Single word (WIDTH=8, PARITY_EN=0): in_data=8'hA5 accepted at edge k -> sdata over cycles k+1..k+8 = 1,0,1,0,0,1,0,1; sframe=1 for exactly 8 cycles; in_ready=1 only on cycle k+8 within the frame.
REQ-028 Back-to-back: 8'h01 then 8'h80, in_valid held high -> 16 consecutive sframe=1 cycles; sdata = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; busy continuous for 16 cycles.
REQ-029 Parity (PARITY_EN=1): 8'h07 -> 9 frame cycles, ninth bit=1; 8'h03 -> ninth bit=0.
REQ-030 Stall: in_valid pulses high for one cycle mid-frame while in_ready=0 -> no acceptance; the block returns to IDLE after the frame, and no extra bits are emitted.
REQ-031 Reset mid-frame: arst=1 asynchronously at the 4th bit of 8'hFF -> sdata, sframe and busy = 0 before the next edge; after release, 8'h0F is sent correctly with no residue from the aborted frame.
REQ-032 Idle: in_valid=0 for 20 cycles after reset -> sframe=0, busy=0, sdata=0, in_ready=1 throughout.
